axil_cmd_master: RTL

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_cmd_master.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI-Lite read or write,
// returns one registered response, and recovers from a silent slave via timeout + drain.
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready,

    output logic [15:0]             wr_count,
    output logic [15:0]             rd_count,
    output logic [15:0]             err_count
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP,
        DRAIN
    } state_t;

    state_t                  state_reg, state_next;
    logic                    cmd_ready_reg, cmd_ready_next;
    logic                    awvalid_reg, awvalid_next;
    logic                    wvalid_reg, wvalid_next;
    logic                    arvalid_reg, arvalid_next;
    logic                    bready_reg, bready_next;
    logic                    rready_reg, rready_next;
    logic [ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
    logic [ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [STRB_WIDTH-1:0]   wstrb_reg, wstrb_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic                    rsp_write_reg, rsp_write_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]              rsp_resp_reg, rsp_resp_next;
    logic                    rsp_timeout_reg, rsp_timeout_next;
    logic [31:0]             timer_reg, timer_next;
    logic [15:0]             wr_count_reg, wr_count_next;
    logic [15:0]             rd_count_reg, rd_count_next;
    logic [15:0]             err_count_reg, err_count_next;

    logic timeout_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Fires in the last waiting cycle so the response phase lasts exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = TIMEOUT_EN && (timer_reg == TIMEOUT_LAST);

    always_comb begin
        state_next       = state_reg;
        cmd_ready_next   = cmd_ready_reg;
        awvalid_next     = awvalid_reg;
        wvalid_next      = wvalid_reg;
        arvalid_next     = arvalid_reg;
        bready_next      = bready_reg;
        rready_next      = rready_reg;
        awaddr_next      = awaddr_reg;
        araddr_next      = araddr_reg;
        wdata_next       = wdata_reg;
        wstrb_next       = wstrb_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_write_next   = rsp_write_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_resp_next    = rsp_resp_reg;
        rsp_timeout_next = rsp_timeout_reg;
        timer_next       = timer_reg;
        wr_count_next    = wr_count_reg;
        rd_count_next    = rd_count_reg;
        err_count_next   = err_count_reg;

        case (state_reg)
            IDLE: begin
                cmd_ready_next = 1'b1;
                if (cmd_valid && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
                    if (cmd_write) begin
                        awaddr_next  = cmd_addr;
                        wdata_next   = cmd_wdata;
                        wstrb_next   = cmd_wstrb;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR_REQ;
                    end else begin
                        araddr_next  = cmd_addr;
                        arvalid_next = 1'b1;
                        state_next   = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                // AW and W complete independently, in either order.
                awvalid_next = awvalid_reg && !m_axil_awready;
                wvalid_next  = wvalid_reg && !m_axil_wready;
                if (!awvalid_next && !wvalid_next) begin
                    bready_next = 1'b1;
                    timer_next  = 32'd0;
                    state_next  = WR_RESP;
                end
            end

            WR_RESP: begin
                timer_next = timer_reg + 32'd1;
                if (m_axil_bvalid && bready_reg) begin
                    bready_next      = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_write_next   = 1'b1;
                    rsp_rdata_next   = '0;
                    rsp_resp_next    = m_axil_bresp;
                    rsp_timeout_next = 1'b0;
                    state_next       = RSP;
                end else if (timeout_hit) begin
                    bready_next      = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_write_next   = 1'b1;
                    rsp_rdata_next   = '0;
                    rsp_resp_next    = 2'b10;
                    rsp_timeout_next = 1'b1;
                    state_next       = RSP;
                end
            end

            RD_REQ: begin
                if (m_axil_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    timer_next   = 32'd0;
                    state_next   = RD_DATA;
                end
            end

            RD_DATA: begin
                timer_next = timer_reg + 32'd1;
                if (m_axil_rvalid && rready_reg) begin
                    rready_next      = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_write_next   = 1'b0;
                    rsp_rdata_next   = m_axil_rdata;
                    rsp_resp_next    = m_axil_rresp;
                    rsp_timeout_next = 1'b0;
                    state_next       = RSP;
                end else if (timeout_hit) begin
                    rready_next      = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_write_next   = 1'b0;
                    rsp_rdata_next   = '0;
                    rsp_resp_next    = 2'b10;
                    rsp_timeout_next = 1'b1;
                    state_next       = RSP;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    if (rsp_write_reg) begin
                        wr_count_next = sat_inc(wr_count_reg);
                    end else begin
                        rd_count_next = sat_inc(rd_count_reg);
                    end
                    if ((rsp_resp_reg != 2'b00) || rsp_timeout_reg) begin
                        err_count_next = sat_inc(err_count_reg);
                    end
                    // After a timeout the slave may still owe us a beat; swallow it before new work.
                    if (rsp_timeout_reg) begin
                        bready_next = rsp_write_reg;
                        rready_next = !rsp_write_reg;
                        state_next  = DRAIN;
                    end else begin
                        cmd_ready_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
            end

            DRAIN: begin
                if ((m_axil_bvalid && bready_reg) || (m_axil_rvalid && rready_reg)) begin
                    bready_next    = 1'b0;
                    rready_next    = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_reg       <= IDLE;
            cmd_ready_reg   <= 1'b0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            bready_reg      <= 1'b0;
            rready_reg      <= 1'b0;
            awaddr_reg      <= '0;
            araddr_reg      <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_write_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= 2'b00;
            rsp_timeout_reg <= 1'b0;
            timer_reg       <= 32'd0;
            wr_count_reg    <= 16'd0;
            rd_count_reg    <= 16'd0;
            err_count_reg   <= 16'd0;
        end else begin
            state_reg       <= state_next;
            cmd_ready_reg   <= cmd_ready_next;
            awvalid_reg     <= awvalid_next;
            wvalid_reg      <= wvalid_next;
            arvalid_reg     <= arvalid_next;
            bready_reg      <= bready_next;
            rready_reg      <= rready_next;
            awaddr_reg      <= awaddr_next;
            araddr_reg      <= araddr_next;
            wdata_reg       <= wdata_next;
            wstrb_reg       <= wstrb_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_write_reg   <= rsp_write_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_resp_reg    <= rsp_resp_next;
            rsp_timeout_reg <= rsp_timeout_next;
            timer_reg       <= timer_next;
            wr_count_reg    <= wr_count_next;
            rd_count_reg    <= rd_count_next;
            err_count_reg   <= err_count_next;
        end
    end

    assign cmd_ready      = cmd_ready_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_write      = rsp_write_reg;
    assign rsp_rdata      = rsp_rdata_reg;
    assign rsp_resp       = rsp_resp_reg;
    assign rsp_timeout    = rsp_timeout_reg;
    assign m_axil_awaddr  = awaddr_reg;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_reg;
    assign m_axil_wdata   = wdata_reg;
    assign m_axil_wstrb   = wstrb_reg;
    assign m_axil_wvalid  = wvalid_reg;
    assign m_axil_bready  = bready_reg;
    assign m_axil_araddr  = araddr_reg;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_reg;
    assign m_axil_rready  = rready_reg;
    assign wr_count       = wr_count_reg;
    assign rd_count       = rd_count_reg;
    assign err_count      = err_count_reg;

endmodule
